nco_clock_gen: RTL and testbench

//  Multi-channel numerically-controlled clock-enable generator; fabric successor to the fixed single-output PLL wrapper.

---
 rtl/nco_clock_gen_pkg.sv | 19 +
 rtl/nco_clock_gen_if.sv | 31 +++
 rtl/nco_channel.sv | 98 +++++++++
 rtl/nco_clock_gen.sv | 91 +++++++++
 tb/tb_nco_clock_gen.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/nco_clock_gen_pkg.sv
// Shared types and defaults for the multi-channel NCO clock-enable generator.
package nco_clock_gen_pkg;

  localparam int unsigned NCO_ACC_W       = 32;
  localparam int unsigned NCO_LOCK_CYCLES = 16;

  typedef struct packed {
    logic [NCO_ACC_W-1:0] freq;
    logic [NCO_ACC_W-1:0] phase;
    logic [NCO_ACC_W-1:0] duty;
    logic                 enable;
  } nco_cfg_t;

  // Channel-select width; a single-channel build still carries a 1-bit select.
  function automatic int unsigned chan_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nco_clock_gen_if.sv
// Config write port plus per-channel clock/tick outputs and lock status.
interface nco_clock_gen_if
  import nco_clock_gen_pkg::*;
#(
  parameter int unsigned NUM_CLOCKS = 4,
  parameter int unsigned ACC_W      = NCO_ACC_W
);
  localparam int unsigned CHAN_W = chan_width(NUM_CLOCKS);

  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [CHAN_W-1:0]     cfg_chan;
  logic [ACC_W-1:0]      cfg_freq;
  logic [ACC_W-1:0]      cfg_phase;
  logic [ACC_W-1:0]      cfg_duty;
  logic                  cfg_enable;
  logic [NUM_CLOCKS-1:0] outclk;
  logic [NUM_CLOCKS-1:0] outtick;
  logic                  locked;

  modport master (
    output cfg_valid, cfg_chan, cfg_freq, cfg_phase, cfg_duty, cfg_enable,
    input  cfg_ready, outclk, outtick, locked
  );

  modport slave (
    input  cfg_valid, cfg_chan, cfg_freq, cfg_phase, cfg_duty, cfg_enable,
    output cfg_ready, outclk, outtick, locked
  );

endinterface

// File: rtl/nco_channel.sv
// One NCO channel: phase accumulator, active/shadow config and glitch-free commit.
module nco_channel
  import nco_clock_gen_pkg::*;
#(
  parameter int unsigned ACC_W = NCO_ACC_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_i,
  input  logic [ACC_W-1:0] freq_i,
  input  logic [ACC_W-1:0] phase_i,
  input  logic [ACC_W-1:0] duty_i,
  input  logic             enable_i,
  output logic             pending_o,
  output logic             busy_o,
  output logic             enabled_o,
  output logic             outclk_o,
  output logic             outtick_o
);

  typedef struct packed {
    logic [ACC_W-1:0] freq;
    logic [ACC_W-1:0] phase;
    logic [ACC_W-1:0] duty;
    logic             enable;
  } shadow_t;

  shadow_t          shd_q, shd_d;
  logic [ACC_W-1:0] freq_q, freq_d;
  logic [ACC_W-1:0] duty_q, duty_d;
  logic             en_q, en_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic [ACC_W:0]   sum;
  logic             wrap;
  logic             apply;

  always_comb begin
    sum    = {1'b0, acc_q} + {1'b0, freq_q};
    wrap   = en_q & sum[ACC_W];
    // A stopped channel (disabled or zero step) never wraps, so it commits at once.
    apply  = pend_q & (wrap | ~en_q | (freq_q == '0));
    shd_d  = shd_q;
    freq_d = freq_q;
    duty_d = duty_q;
    en_d   = en_q;
    acc_d  = acc_q;
    pend_d = pend_q;
    clk_d  = 1'b0;
    tick_d = wrap;
    if (wr_i) begin
      shd_d  = '{freq: freq_i, phase: phase_i, duty: duty_i, enable: enable_i};
      pend_d = 1'b1;
    end
    if (apply) begin
      freq_d = shd_q.freq;
      duty_d = shd_q.duty;
      en_d   = shd_q.enable;
      acc_d  = shd_q.phase;
      pend_d = 1'b0;
      clk_d  = shd_q.enable & (shd_q.phase < shd_q.duty);
    end else if (en_q) begin
      acc_d = sum[ACC_W-1:0];
      clk_d = sum[ACC_W-1:0] < duty_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shd_q  <= '0;
      freq_q <= '0;
      duty_q <= '0;
      en_q   <= 1'b0;
      acc_q  <= '0;
      pend_q <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      shd_q  <= shd_d;
      freq_q <= freq_d;
      duty_q <= duty_d;
      en_q   <= en_d;
      acc_q  <= acc_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign pending_o = pend_q;
  assign busy_o    = pend_d;
  assign enabled_o = en_q;
  assign outclk_o  = clk_q;
  assign outtick_o = tick_q;

endmodule

// File: rtl/nco_clock_gen.sv
// Multi-channel NCO clock-enable generator: config decode, channel array, lock tracking.
module nco_clock_gen
  import nco_clock_gen_pkg::*;
#(
  parameter int unsigned NUM_CLOCKS  = 4,
  parameter int unsigned ACC_W       = NCO_ACC_W,
  parameter int unsigned LOCK_CYCLES = NCO_LOCK_CYCLES
) (
  input logic           refclk,
  input logic           rst,
  nco_clock_gen_if.slave bus
);

  localparam int unsigned CHAN_W = chan_width(NUM_CLOCKS);
  localparam int unsigned CNT_W  = $clog2(LOCK_CYCLES + 1);

  logic [NUM_CLOCKS-1:0] wr;
  logic [NUM_CLOCKS-1:0] pend;
  logic [NUM_CLOCKS-1:0] busy;
  logic [NUM_CLOCKS-1:0] en;
  logic [NUM_CLOCKS-1:0] clk_v;
  logic [NUM_CLOCKS-1:0] tick_v;
  logic                  ready;
  logic                  accept;
  logic                  reload;
  logic                  any_en;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  locked_q, locked_d;

  // Out-of-range channel selects stay ready and write nothing.
  always_comb begin
    wr    = '0;
    ready = 1'b1;
    for (int unsigned i = 0; i < NUM_CLOCKS; i++) begin
      if (bus.cfg_chan == CHAN_W'(i)) begin
        ready = ~pend[i];
        wr[i] = bus.cfg_valid & ~pend[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_chan
    nco_channel #(
      .ACC_W(ACC_W)
    ) u_chan (
      .clk_i    (refclk),
      .rst_i    (rst),
      .wr_i     (wr[g]),
      .freq_i   (bus.cfg_freq),
      .phase_i  (bus.cfg_phase),
      .duty_i   (bus.cfg_duty),
      .enable_i (bus.cfg_enable),
      .pending_o(pend[g]),
      .busy_o   (busy[g]),
      .enabled_o(en[g]),
      .outclk_o (clk_v[g]),
      .outtick_o(tick_v[g])
    );
  end

  assign accept = |wr;
  assign reload = accept | (|busy);
  assign any_en = |en;

  // Quiet cycles are counted from the edge that clears the last pending update.
  always_comb begin
    cnt_d = cnt_q;
    if (reload) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(LOCK_CYCLES)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    locked_d = ~reload & any_en & (cnt_q >= CNT_W'(LOCK_CYCLES - 1));
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
    end
  end

  assign bus.cfg_ready = ready;
  assign bus.outclk    = clk_v;
  assign bus.outtick   = tick_v;
  assign bus.locked    = locked_q;

endmodule

// File: tb/tb_nco_clock_gen.sv
// Directed bench for nco_clock_gen: 4-channel main build plus a 5-channel build for invalid selects.
module tb_nco_clock_gen;
  import nco_clock_gen_pkg::*;

  logic        refclk = 1'b0;
  logic        rst    = 1'b1;
  int unsigned n_pass  = 0;
  int unsigned n_fail  = 0;
  int unsigned n_total = 0;

  nco_clock_gen_if #(.NUM_CLOCKS(4), .ACC_W(32)) if4 ();
  nco_clock_gen_if #(.NUM_CLOCKS(5), .ACC_W(32)) if5 ();

  nco_clock_gen #(.NUM_CLOCKS(4), .ACC_W(32), .LOCK_CYCLES(16)) u_dut (
    .refclk(refclk),
    .rst   (rst),
    .bus   (if4)
  );

  nco_clock_gen #(.NUM_CLOCKS(5), .ACC_W(32), .LOCK_CYCLES(16)) u_dut5 (
    .refclk(refclk),
    .rst   (rst),
    .bus   (if5)
  );

  always #5 refclk = ~refclk;

  function automatic nco_cfg_t mk(input logic [31:0] f, input logic [31:0] p,
                                  input logic [31:0] d, input logic e);
    mk = '{freq: f, phase: p, duty: d, enable: e};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic write4(input logic [1:0] ch, input nco_cfg_t c);
    if4.cfg_chan   = ch;
    if4.cfg_freq   = c.freq;
    if4.cfg_phase  = c.phase;
    if4.cfg_duty   = c.duty;
    if4.cfg_enable = c.enable;
    if4.cfg_valid  = 1'b1;
    @(posedge refclk);
    #1;
    if4.cfg_valid = 1'b0;
  endtask

  initial begin
    logic [11:0] vc0, vt0, vc1, vt1;
    logic [4:0]  seen5;
    if4.cfg_valid = 1'b0; if4.cfg_chan = '0; if4.cfg_freq = '0;
    if4.cfg_phase = '0;   if4.cfg_duty = '0; if4.cfg_enable = 1'b0;
    if5.cfg_valid = 1'b0; if5.cfg_chan = '0; if5.cfg_freq = '0;
    if5.cfg_phase = '0;   if5.cfg_duty = '0; if5.cfg_enable = 1'b0;

    step(3);
    rst = 1'b0;
    chk("rst_outclk", if4.outclk, 4'b0000);
    chk("rst_outtick", if4.outtick, 4'b0000);
    chk("rst_locked", if4.locked, 1'b0);
    chk("rst_ready", if4.cfg_ready, 1'b1);

    // ch0: quarter-turn step, half duty; accept edge is E0
    write4(2'd0, mk(32'h4000_0000, 32'h0, 32'h8000_0000, 1'b1));
    chk("t2_ready_pending", if4.cfg_ready, 1'b0);
    chk("t2_locked_low", if4.locked, 1'b0);
    step(1);
    chk("t2_ready_free", if4.cfg_ready, 1'b1);
    vc0 = '0; vt0 = '0;
    for (int i = 0; i < 8; i++) begin
      vc0 = {vc0[10:0], if4.outclk[0]};
      vt0 = {vt0[10:0], if4.outtick[0]};
      step(1);
    end
    chk("t2_clk0_wave", vc0[7:0], 8'b1100_1100);
    chk("t2_tick0_wave", vt0[7:0], 8'b0000_1000);
    step(6);
    chk("t2_locked_e15", if4.locked, 1'b0);
    step(1);
    chk("t2_locked_e16", if4.locked, 1'b1);

    // ch1 half-turn phase, committed on the ch0 wrap at E21
    step(3);
    write4(2'd1, mk(32'h4000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1));
    chk("t3_ready_pending", if4.cfg_ready, 1'b0);
    chk("t3_locked_drop", if4.locked, 1'b0);
    step(1);
    vc0 = '0; vt0 = '0; vc1 = '0; vt1 = '0;
    for (int i = 0; i < 8; i++) begin
      vc0 = {vc0[10:0], if4.outclk[0]};
      vt0 = {vt0[10:0], if4.outtick[0]};
      vc1 = {vc1[10:0], if4.outclk[1]};
      vt1 = {vt1[10:0], if4.outtick[1]};
      step(1);
    end
    chk("t3_clk0_wave", vc0[7:0], 8'b1100_1100);
    chk("t3_tick0_wave", vt0[7:0], 8'b1000_1000);
    chk("t3_clk1_wave", vc1[7:0], 8'b0011_0011);
    chk("t3_tick1_wave", vt1[7:0], 8'b0010_0010);

    // ch0 reprogrammed mid-period (E30); second write stalls until the E33 wrap
    write4(2'd0, mk(32'h2000_0000, 32'h0, 32'h8000_0000, 1'b1));
    chk("t4_ready_pending", if4.cfg_ready, 1'b0);
    if4.cfg_freq  = 32'h1000_0000;
    if4.cfg_valid = 1'b1;
    vc0 = '0; vt0 = '0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      vc0 = {vc0[10:0], if4.outclk[0]};
      vt0 = {vt0[10:0], if4.outtick[0]};
      if (i < 2) chk("t4_stall_ready", if4.cfg_ready, 1'b0);
      if (i == 1) if4.cfg_valid = 1'b0;
      if (i == 2) chk("t4_ready_after_wrap", if4.cfg_ready, 1'b1);
    end
    chk("t4_clk0_wave", vc0[9:0], 10'b00_1111_0000);
    chk("t4_tick0_wave", vt0[9:0], 10'b00_1000_0000);
    chk("t4_locked_low", if4.locked, 1'b0);

    // ch0 disable accepted on its own wrap (E41): commits at the following wrap (E49)
    write4(2'd0, mk(32'h2000_0000, 32'h0, 32'h8000_0000, 1'b0));
    vc0 = '0; vt0 = '0;
    for (int i = 0; i < 12; i++) begin
      vc0 = {vc0[10:0], if4.outclk[0]};
      vt0 = {vt0[10:0], if4.outtick[0]};
      if (i == 7) chk("t5_ready_held", if4.cfg_ready, 1'b0);
      if (i == 8) chk("t5_ready_commit", if4.cfg_ready, 1'b1);
      step(1);
    end
    chk("t5_clk0_wave", vc0, 12'b1111_0000_0000);
    chk("t5_tick0_wave", vt0, 12'b1000_0000_1000);

    // ch2 zero step: constant level, commits immediately each time
    write4(2'd2, mk(32'h0, 32'h0, 32'h1, 1'b1));
    chk("t5_ch2_ready_pending", if4.cfg_ready, 1'b0);
    chk("t5_ch2_clk_before", if4.outclk[2], 1'b0);
    step(1);
    chk("t5_ch2_clk_high", if4.outclk[2], 1'b1);
    chk("t5_ch2_ready_free", if4.cfg_ready, 1'b1);
    step(3);
    chk("t5_ch2_clk_steady", if4.outclk[2], 1'b1);
    chk("t5_ch2_no_tick", if4.outtick[2], 1'b0);
    write4(2'd2, mk(32'h0, 32'h0, 32'h0, 1'b1));
    step(1);
    chk("t5_ch2_duty0_low", if4.outclk[2], 1'b0);
    chk("t5_ch2_ready_again", if4.cfg_ready, 1'b1);
    step(14);
    chk("t5_locked_e74", if4.locked, 1'b0);
    step(1);
    chk("t5_locked_e75", if4.locked, 1'b1);
    chk("t5_outclk_e75", if4.outclk, 4'b0010);
    chk("t5_outtick_e75", if4.outtick, 4'b0010);

    // async reset with an update pending on ch1
    write4(2'd1, mk(32'h1000_0000, 32'h0, 32'h8000_0000, 1'b1));
    chk("t1_ready_pending", if4.cfg_ready, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("t1_async_outclk", if4.outclk, 4'b0000);
    chk("t1_async_outtick", if4.outtick, 4'b0000);
    chk("t1_async_locked", if4.locked, 1'b0);
    chk("t1_async_ready", if4.cfg_ready, 1'b1);
    step(2);
    rst = 1'b0;
    vc0 = '0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      vc0[3:0] = vc0[3:0] | if4.outclk | if4.outtick;
    end
    chk("t1_no_commit_after_rst", vc0[3:0], 4'b0000);
    chk("t1_locked_after_rst", if4.locked, 1'b0);

    // 5-channel build: selects 5 and 7 are accepted and ignored
    if5.cfg_chan   = 3'd5;
    if5.cfg_freq   = 32'h4000_0000;
    if5.cfg_phase  = 32'h0;
    if5.cfg_duty   = 32'h8000_0000;
    if5.cfg_enable = 1'b1;
    if5.cfg_valid  = 1'b1;
    #1;
    chk("t6_ready_chan5", if5.cfg_ready, 1'b1);
    step(1);
    if5.cfg_chan = 3'd7;
    #1;
    chk("t6_ready_chan7", if5.cfg_ready, 1'b1);
    step(1);
    if5.cfg_valid = 1'b0;
    seen5 = '0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      seen5 = seen5 | if5.outclk | if5.outtick;
    end
    chk("t6_no_output", seen5, 5'b00000);
    chk("t6_locked_low", if5.locked, 1'b0);

    // highest valid channel of the 5-channel build still decodes
    if5.cfg_chan  = 3'd4;
    if5.cfg_freq  = 32'h8000_0000;
    if5.cfg_valid = 1'b1;
    step(1);
    if5.cfg_valid = 1'b0;
    chk("t6_ch4_pending", if5.cfg_ready, 1'b0);
    step(1);
    chk("t6_ch4_clk_hi", if5.outclk, 5'b10000);
    step(1);
    chk("t6_ch4_clk_lo", if5.outclk, 5'b00000);
    step(1);
    chk("t6_ch4_tick", if5.outtick, 5'b10000);
    chk("t6_ch4_clk_wrap", if5.outclk, 5'b10000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
